irc_prio: RTL and testbench
===========================

// Module: irc_prio
// PURPOSE
//   Parametrised priority interrupt controller; successor to the 3-bit INT controller.
//   Takes NUM_SRC edge-triggered external sources plus one internal trigger channel.
//   Latches each source in a per-source pending bit, with a per-source mask.
//   Presents one vectored ID at a time to the core on NEXT_ID/NEXT_ON until ACK.
//   Also sequences power-on and software reset (RESET_ON, boot vector RST_ID).
// PARAMETERS
//   NUM_SRC      8   number of external interrupt sources (1..2**ID_W-1)
//   ID_W         4   width of interrupt identifier
//   RST_ID       8   ID presented after reset release; TRIG_ID==RST_ID = software reset
//   SYNC_STAGES  2   synchroniser depth for RST release and SRC inputs (>=2)
// PORTS
//   CLK       in   1        system clock, rising edge
//   RST       in   1        asynchronous active-low reset
//   SRC       in   NUM_SRC  external interrupt lines, asynchronous, rising edge = request
//   MASK      in   NUM_SRC  1 = source i enabled for presentation (pending still latches)
//   TRIG_ID   in   ID_W     internal trigger identifier
//   TRIG_ON   in   1        internal trigger strobe, 1 cycle
//   TRIG_BUSY out  1        internal trigger slot occupied; TRIG_ON ignored while 1
//   ACK       in   1        core acknowledges the presented interrupt
//   NEXT_ID   out  ID_W     presented interrupt ID
//   NEXT_ON   out  1        NEXT_ID valid
//   IRQ       out  1        interrupt request to core, equals NEXT_ON
//   RESET_ON  out  1        reset sequence in progress
//   PENDING   out  NUM_SRC  latched pending bits
// BEHAVIOUR
//   Reset (RST low, async): NEXT_ID=0, NEXT_ON=0, IRQ=0, RESET_ON=1, PENDING=0,
//     TRIG_BUSY=0; all synchroniser and edge-detect flops cleared; state=S_RST.
//   FSM states:
//     S_RST: RST sync chain shifts in 1. When the last stage is 1:
//       NEXT_ID<=RST_ID, NEXT_ON<=1, RESET_ON<=0; go to S_PRES.
//     S_IDLE: choose the lowest-index i with PENDING[i]&MASK[i];
//       if none, choose the trigger slot if TRIG_BUSY.
//       On selection: NEXT_ID<=i (or slot ID), NEXT_ON<=1; go to S_PRES.
//     S_PRES: NEXT_ID stable. ACK -> clear that pending bit or slot; NEXT_ON<=0; go to S_IDLE.
//   Guaranteed >=1 cycle NEXT_ON=0 between consecutive presentations.
//   SRC path: SYNC_STAGES sync flops, then an edge register.
//     A 0->1 on the synced line sets PENDING[i] the next edge.
//     Total SRC rise to PENDING: SYNC_STAGES+1 cycles; NEXT_ON follows 1 cycle later if IDLE.
//   Repeat edges while pending merge into one bit (no count).
//   Edge on a source in the same cycle as its ACK-clear: set wins, PENDING stays 1.
//   MASK change never withdraws an already presented ID; masked pending bits are held.
//   ACK outside S_PRES: ignored. ACK held high: acts once per presentation only.
//   Internal trigger: TRIG_ON with TRIG_BUSY=0 and TRIG_ID!=RST_ID latches the ID; TRIG_BUSY<=1.
//     Lower priority than any unmasked pending source.
//   Software reset: TRIG_ON with TRIG_ID==RST_ID (not gated by TRIG_BUSY) in any state.
//     Next edge: RESET_ON<=1, NEXT_ON<=0, IRQ<=0, PENDING<=0, TRIG_BUSY<=0,
//     RST sync chain cleared; go to S_RST (boot repeats as after RST).
//   RST asserted mid-presentation: immediate async reset; no ACK needed.
//   SRC edges during S_RST are discarded; edge flops only arm after RESET_ON falls.
// TESTING
//   T1 RST low 3 cyc, release -> RESET_ON 1 for SYNC_STAGES+1 edges, then NEXT_ID=8,
//      NEXT_ON=1; ACK -> NEXT_ON=0 next edge.
//   T2 SRC[5] and SRC[2] rise same cycle, MASK=FF -> NEXT_ID=2; ACK; 1 idle cyc;
//      NEXT_ID=5; ACK -> PENDING=00.
//   T3 MASK[3]=0, SRC[3] rise -> PENDING[3]=1, NEXT_ON=0; set MASK[3]=1 -> NEXT_ID=3 next cyc.
//   T4 TRIG_ON ID=0xC, then TRIG_ON ID=0xD while busy -> only 0xC presented;
//      SRC[1] pending first -> 1 presented before 0xC.
//   T5 SRC[4] re-rises during its presentation, ACK same cycle as PENDING set
//      -> PENDING[4]=1, ID 4 re-presented.
//   T6 TRIG_ON ID=8 while ID 6 presented -> RESET_ON=1, PENDING=0, NEXT_ON=0;
//      boot re-presents NEXT_ID=8.

Source files
------------

// File: rtl/irc_prio.sv
// ---------------------------------------------------------------------------
// irc_prio : parametrised priority interrupt controller
//
// Latches rising edges of NUM_SRC asynchronous interrupt lines into per-source
// pending bits and presents one vectored ID at a time to the core until the
// core acknowledges it.  Also holds one internal trigger slot (lowest
// priority) and sequences power-on / software reset, presenting the boot
// vector RST_ID after every reset.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   src        external interrupt lines (async, rising edge = request)
//   mask       1 = source enabled for presentation (pending still latches)
//   trig_id    internal trigger identifier
//   trig_on    internal trigger strobe (1 cycle)
//   trig_busy  internal trigger slot occupied; trig_on ignored while 1
//   ack        core acknowledges the presented interrupt
//   next_id    presented interrupt ID
//   next_on    next_id valid
//   irq        interrupt request to core (same as next_on)
//   reset_on   reset sequence in progress
//   pending    latched pending bits
//   state      FSM state for observation (0 = RST, 1 = IDLE, 2 = PRES)
//
// Handshake: the controller raises next_on with a stable next_id and holds
// both until it samples ack high on a rising edge; that edge drops next_on
// and retires the presented ID.  ack is ignored whenever next_on is low, and
// next_on is always low for at least one cycle between two presentations.
// ---------------------------------------------------------------------------
module irc_prio #(
  parameter int NUM_SRC     = 8,
  parameter int ID_W        = 4,
  parameter int RST_ID      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] mask,
  input  logic [ID_W-1:0]    trig_id,
  input  logic               trig_on,
  output logic               trig_busy,
  input  logic               ack,
  output logic [ID_W-1:0]    next_id,
  output logic               next_on,
  output logic               irq,
  output logic               reset_on,
  output logic [NUM_SRC-1:0] pending,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_IDLE = 2'd1,
    S_PRES = 2'd2
  } state_t;

  state_t fsm;

  logic [NUM_SRC-1:0]     src_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0]     src_prev;
  logic [NUM_SRC-1:0]     rise;
  logic [NUM_SRC-1:0]     clr;
  logic [SYNC_STAGES-1:0] rst_sync;
  logic [ID_W-1:0]        trig_slot;
  logic                   pres_src;   // presented ID is an external source
  logic                   pres_slot;  // presented ID is the trigger slot
  logic                   soft_rst;
  logic                   trig_take;
  logic                   sel_found;
  logic [ID_W-1:0]        sel_id;

  // Plain synchroniser chain for the external lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) src_sync[k] <= '0;
    end else begin
      src_sync[0] <= src;
      for (int k = 1; k < SYNC_STAGES; k++) src_sync[k] <= src_sync[k-1];
    end
  end

  // Edges seen while the reset sequence runs are dropped; src_prev keeps
  // tracking the line so a level already high at boot is not a new edge.
  assign rise      = src_sync[SYNC_STAGES-1] & ~src_prev & {NUM_SRC{~reset_on}};
  assign soft_rst  = trig_on && (trig_id == ID_W'(RST_ID));
  assign trig_take = trig_on && !trig_busy && (trig_id != ID_W'(RST_ID));

  // Lowest index among unmasked pending sources wins.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i] && mask[i]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(i);
      end
    end
  end

  // Pending bit retired by an ack of the presented source.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = (fsm == S_PRES) && ack && pres_src && (next_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_RST;
      rst_sync  <= '0;
      src_prev  <= '0;
      pending   <= '0;
      trig_busy <= 1'b0;
      trig_slot <= '0;
      next_id   <= '0;
      next_on   <= 1'b0;
      reset_on  <= 1'b1;
      pres_src  <= 1'b0;
      pres_slot <= 1'b0;
    end else begin
      src_prev <= src_sync[SYNC_STAGES-1];
      if (soft_rst) begin
        // Software reset overrides everything, in any state.
        fsm       <= S_RST;
        rst_sync  <= '0;
        pending   <= '0;
        trig_busy <= 1'b0;
        next_on   <= 1'b0;
        reset_on  <= 1'b1;
        pres_src  <= 1'b0;
        pres_slot <= 1'b0;
      end else begin
        // A new edge beats a simultaneous ack-clear of the same bit.
        pending <= (pending & ~clr) | rise;
        if (trig_take) begin
          trig_busy <= 1'b1;
          trig_slot <= trig_id;
        end
        case (fsm)
          S_RST: begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
            if (rst_sync[SYNC_STAGES-1]) begin
              next_id   <= ID_W'(RST_ID);
              next_on   <= 1'b1;
              reset_on  <= 1'b0;
              pres_src  <= 1'b0;
              pres_slot <= 1'b0;
              fsm       <= S_PRES;
            end
          end
          S_IDLE: begin
            if (sel_found) begin
              next_id   <= sel_id;
              next_on   <= 1'b1;
              pres_src  <= 1'b1;
              pres_slot <= 1'b0;
              fsm       <= S_PRES;
            end else if (trig_busy) begin
              next_id   <= trig_slot;
              next_on   <= 1'b1;
              pres_src  <= 1'b0;
              pres_slot <= 1'b1;
              fsm       <= S_PRES;
            end
          end
          S_PRES: begin
            if (ack) begin
              next_on <= 1'b0;
              if (pres_slot) trig_busy <= 1'b0;
              pres_src  <= 1'b0;
              pres_slot <= 1'b0;
              fsm       <= S_IDLE;
            end
          end
          default: fsm <= S_RST;
        endcase
      end
    end
  end

  assign irq   = next_on;
  assign state = fsm;

endmodule

// File: tb/tb_irc_prio.sv
// ---------------------------------------------------------------------------
// tb_irc_prio : directed bench for irc_prio (NUM_SRC=8, ID_W=4, RST_ID=8,
// SYNC_STAGES=2).  Inputs change 1 ns after a rising edge; outputs are
// checked at the same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_irc_prio;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 4;

  logic               clk;
  logic               rst_n;
  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] mask;
  logic [ID_W-1:0]    trig_id;
  logic               trig_on;
  logic               trig_busy;
  logic               ack;
  logic [ID_W-1:0]    next_id;
  logic               next_on;
  logic               irq;
  logic               reset_on;
  logic [NUM_SRC-1:0] pending;
  logic [1:0]         state;

  int checks = 0;
  int errors = 0;

  irc_prio #(
    .NUM_SRC(NUM_SRC), .ID_W(ID_W), .RST_ID(8), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src(src), .mask(mask),
    .trig_id(trig_id), .trig_on(trig_on), .trig_busy(trig_busy),
    .ack(ack), .next_id(next_id), .next_on(next_on), .irq(irq),
    .reset_on(reset_on), .pending(pending), .state(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presented ID and request line together.
  task automatic check_pres(input string tag, input logic [ID_W-1:0] exp_id);
    check({tag, "_on"},  32'(next_on), 32'd1);
    check({tag, "_irq"}, 32'(irq),     32'd1);
    check({tag, "_id"},  32'(next_id), 32'(exp_id));
  endtask

  initial begin
    rst_n   = 1'b0;
    src     = '0;
    mask    = 8'hFF;
    trig_id = '0;
    trig_on = 1'b0;
    ack     = 1'b0;

    // T1: power-on reset and boot vector
    tick(3);
    check("rst_next_on",  32'(next_on),   32'd0);
    check("rst_irq",      32'(irq),       32'd0);
    check("rst_reset_on", 32'(reset_on),  32'd1);
    check("rst_pending",  32'(pending),   32'd0);
    check("rst_busy",     32'(trig_busy), 32'd0);
    check("rst_next_id",  32'(next_id),   32'd0);
    check("rst_state",    32'(state),     32'd0);
    rst_n = 1'b1;
    tick(2);
    check("boot_hold_reset_on", 32'(reset_on), 32'd1);
    check("boot_hold_next_on",  32'(next_on),  32'd0);
    tick();
    check("boot_reset_on", 32'(reset_on), 32'd0);
    check_pres("boot", 4'h8);
    ack = 1'b1;
    tick();
    check("boot_ack_on", 32'(next_on), 32'd0);
    ack = 1'b0;

    // T2: two simultaneous sources, lower index first
    src = 8'h24;
    tick(3);
    check("t2_pending", 32'(pending), 32'h24);
    check("t2_wait_on", 32'(next_on), 32'd0);
    tick();
    check_pres("t2_first", 4'h2);
    ack = 1'b1;
    tick();
    check("t2_gap_on",   32'(next_on), 32'd0);
    check("t2_pending2", 32'(pending), 32'h20);
    ack = 1'b0;
    tick();
    check_pres("t2_second", 4'h5);
    ack = 1'b1;
    tick();
    check("t2_done_on",      32'(next_on), 32'd0);
    check("t2_done_pending", 32'(pending), 32'h00);
    ack = 1'b0;
    src = '0;
    tick(3);

    // T3: masked source latches but is held; ack while idle is ignored
    mask = 8'hF7;
    src  = 8'h08;
    tick(3);
    check("t3_pending", 32'(pending), 32'h08);
    tick();
    check("t3_masked_on", 32'(next_on), 32'd0);
    mask = 8'hFF;
    ack  = 1'b1;
    tick();
    check_pres("t3_unmask", 4'h3);
    tick();
    check("t3_ack_on",      32'(next_on), 32'd0);
    check("t3_ack_pending", 32'(pending), 32'h00);
    ack = 1'b0;
    src = '0;
    tick(3);

    // T4: trigger slot, busy rejects a second trigger, sources win
    src = 8'h02;
    tick(3);
    check("t4_pending", 32'(pending), 32'h02);
    trig_on = 1'b1;
    trig_id = 4'hC;
    tick();
    check_pres("t4_src1", 4'h1);
    check("t4_busy", 32'(trig_busy), 32'd1);
    trig_id = 4'hD;
    tick();
    check("t4_busy2", 32'(trig_busy), 32'd1);
    trig_on = 1'b0;
    ack     = 1'b1;
    tick();
    check("t4_ack1_on", 32'(next_on), 32'd0);
    ack = 1'b0;
    tick();
    check_pres("t4_slot", 4'hC);
    ack = 1'b1;
    tick();
    check("t4_slot_ack_on", 32'(next_on),   32'd0);
    check("t4_slot_free",   32'(trig_busy), 32'd0);
    ack = 1'b0;
    tick();
    check("t4_no_0xd_on", 32'(next_on), 32'd0);
    src = '0;
    tick(3);

    // T5: re-rise of a source lands on the same edge as its ack
    src = 8'h10;
    tick(4);
    check_pres("t5_first", 4'h4);
    src = 8'h00;
    tick(3);
    src = 8'h10;
    tick(2);
    ack = 1'b1;
    tick();
    check("t5_set_wins", 32'(pending), 32'h10);
    check("t5_gap_on",   32'(next_on), 32'd0);
    ack = 1'b0;
    tick();
    check_pres("t5_again", 4'h4);
    ack = 1'b1;
    tick();
    check("t5_done_pending", 32'(pending), 32'h00);
    ack = 1'b0;
    src = '0;
    tick(3);

    // T6: software reset while ID 6 is presented
    src     = 8'h40;
    tick(3);
    trig_on = 1'b1;
    trig_id = 4'hA;
    tick();
    check_pres("t6_src6", 4'h6);
    check("t6_busy", 32'(trig_busy), 32'd1);
    trig_id = 4'h8;
    tick();
    trig_on = 1'b0;
    check("t6_reset_on", 32'(reset_on),  32'd1);
    check("t6_next_on",  32'(next_on),   32'd0);
    check("t6_irq",      32'(irq),       32'd0);
    check("t6_pending",  32'(pending),   32'h00);
    check("t6_busy_clr", 32'(trig_busy), 32'd0);
    tick(2);
    check("t6_boot_hold", 32'(reset_on), 32'd1);
    tick();
    check("t6_boot_reset_on", 32'(reset_on), 32'd0);
    check_pres("t6_boot", 4'h8);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(2);
    check("t6_level_not_edge", 32'(pending), 32'h00);
    check("t6_idle_on",        32'(next_on), 32'd0);
    src = '0;
    tick(3);

    // Async reset mid-presentation, no clock edge needed
    src = 8'h01;
    tick(4);
    check_pres("ar_src0", 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_next_on",  32'(next_on),  32'd0);
    check("ar_reset_on", 32'(reset_on), 32'd1);
    check("ar_pending",  32'(pending),  32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
